// File: rtl/ram64_arbiter.sv
// ram64_arbiter: round-robin front end sharing one RAM64 between requesters A and B,
// with a zero-fill sweep of the RAM after reset.
module ram64_arbiter #(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 6,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_addr;
    logic              last_b, a_sel, b_sel;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
        end

    always_comb state_nx = (state == CLEAR && &clr_addr) ? RUN : state;

    // Winner selection ignores reset so the flops never see reset as data; outputs are gated below.
    always_comb begin
        a_sel    = state == RUN && a_req && (!b_req || last_b);
        b_sel    = state == RUN && b_req && !a_sel;
        a_gnt    = a_sel && !reset;
        b_gnt    = b_sel && !reset;
        busy     = reset || state == CLEAR;
        ram_load = !reset && (state == CLEAR || (a_sel && a_we) || (b_sel && b_we));
        ram_addr = state == CLEAR ? clr_addr : a_sel ? a_addr : b_sel ? b_addr : '0;
        ram_in   = state == CLEAR ? CLEAR_VALUE : a_sel ? a_wdata : b_sel ? b_wdata : '0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            last_b   <= 1'b1;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            last_b   <= a_sel ? 1'b0 : b_sel ? 1'b1 : last_b;
            a_rvalid <= a_sel && !a_we;
            b_rvalid <= b_sel && !b_we;
            if (a_sel && !a_we) a_rdata <= ram_out;
            if (b_sel && !b_we) b_rdata <= ram_out;
        end
endmodule

// File: tb/tb_ram64_arbiter.sv
// tb_ram64_arbiter: directed vectors plus clear/reset sequences against a behavioural RAM64.
module tb_ram64_arbiter;
    logic        clk, reset;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [5:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [5:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [15:0] ram_in, ram_out;
    logic [5:0]  ram_addr;
    logic        ram_load, busy;
    logic [15:0] mem [64];
    int          tests = 0, fails = 0;

    ram64_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load),
        .ram_out(ram_out), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
    always @(posedge clk) if (ram_load) mem[ram_addr] <= ram_in;
    assign ram_out = mem[ram_addr];

    typedef struct {
        int ar, aw, aa, ad, br, bw, ba, bd;
        int eag, ebg, eld, eaddr, ein, earv, ebrv, eard, ebrd;
    } vec_t;
    vec_t tv [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Walks the clear sweep from the negedge after release; abort_at >= 0 asserts reset at that address.
    task automatic run_clear(input int abort_at);
        int n = 0;
        while (n < 70) begin
            @(negedge clk);
            if (!busy) break;
            check("clr_load", ram_load, 1);
            check("clr_addr", ram_addr, n);
            check("clr_gnt", {a_gnt, b_gnt}, 0);
            if (n == abort_at) begin
                reset = 1;
                #1;
                check("abort_busy", busy, 1);
                check("abort_load", ram_load, 0);
                return;
            end
            n++;
        end
        check("clr_len", n, 64);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{1,1,5,16'hBEEF, 0,0,0,0,        1,0,1,5,16'hBEEF,  0,0,0,0};
        tv[1]  = '{1,0,5,0,        0,0,0,0,        1,0,0,5,0,         0,0,0,0};
        tv[2]  = '{0,0,0,0,        0,0,0,0,        0,0,0,0,0,         1,0,16'hBEEF,0};
        tv[3]  = '{1,1,1,16'h0011, 0,0,0,0,        1,0,1,1,16'h0011,  0,0,16'hBEEF,0};
        tv[4]  = '{0,0,0,0,        1,1,2,16'h0022, 0,1,1,2,16'h0022,  0,0,16'hBEEF,0};
        tv[5]  = '{1,0,1,0,        1,0,2,0,        1,0,0,1,0,         0,0,16'hBEEF,0};
        tv[6]  = '{1,0,1,0,        1,0,2,0,        0,1,0,2,0,         1,0,16'h0011,0};
        tv[7]  = '{1,0,1,0,        1,0,2,0,        1,0,0,1,0,         0,1,16'h0011,16'h0022};
        tv[8]  = '{1,0,1,0,        1,0,2,0,        0,1,0,2,0,         1,0,16'h0011,16'h0022};
        tv[9]  = '{1,0,1,0,        1,0,2,0,        1,0,0,1,0,         0,1,16'h0011,16'h0022};
        tv[10] = '{1,0,1,0,        1,0,2,0,        0,1,0,2,0,         1,0,16'h0011,16'h0022};
        tv[11] = '{1,1,63,16'h1234,1,0,63,0,       1,0,1,63,16'h1234, 0,1,16'h0011,16'h0022};
        tv[12] = '{0,0,0,0,        1,0,63,0,       0,1,0,63,0,        0,0,16'h0011,16'h0022};
        tv[13] = '{0,0,0,0,        0,0,0,0,        0,0,0,0,0,         0,1,16'h0011,16'h1234};

        // Reset with both requesters already asking for addr 37
        reset = 1;
        a_req = 1; a_we = 0; a_addr = 37; a_wdata = 0;
        b_req = 1; b_we = 0; b_addr = 37; b_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_gnt", {a_gnt, b_gnt}, 0);
        check("rst_load", ram_load, 0);
        check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        @(posedge clk); #1 reset = 0;
        run_clear(-1);
        check("run1_busy", busy, 0);
        check("run1_gnt", {a_gnt, b_gnt}, 2'b10);
        check("run1_addr", ram_addr, 37);
        check("run1_load", ram_load, 0);
        @(posedge clk); #1 a_req = 0;
        @(negedge clk);
        check("run2_gnt", {a_gnt, b_gnt}, 2'b01);
        check("run2_arv", a_rvalid, 1);
        check("run2_ard", a_rdata, 16'h0000);
        check("run2_brv", b_rvalid, 0);
        @(posedge clk); #1 b_req = 0;
        @(negedge clk);
        check("run3_brv", b_rvalid, 1);
        check("run3_arv", a_rvalid, 0);
        check("run3_brd", b_rdata, 16'h0000);

        foreach (tv[i]) begin
            @(posedge clk); #1;
            a_req = tv[i].ar[0]; a_we = tv[i].aw[0]; a_addr = tv[i].aa[5:0]; a_wdata = tv[i].ad[15:0];
            b_req = tv[i].br[0]; b_we = tv[i].bw[0]; b_addr = tv[i].ba[5:0]; b_wdata = tv[i].bd[15:0];
            @(negedge clk);
            check($sformatf("v%0d_agnt", i), a_gnt, tv[i].eag);
            check($sformatf("v%0d_bgnt", i), b_gnt, tv[i].ebg);
            check($sformatf("v%0d_load", i), ram_load, tv[i].eld);
            check($sformatf("v%0d_addr", i), ram_addr, tv[i].eaddr);
            check($sformatf("v%0d_in", i), ram_in, tv[i].ein);
            check($sformatf("v%0d_arv", i), a_rvalid, tv[i].earv);
            check($sformatf("v%0d_brv", i), b_rvalid, tv[i].ebrv);
            check($sformatf("v%0d_ard", i), a_rdata, tv[i].eard);
            check($sformatf("v%0d_brd", i), b_rdata, tv[i].ebrd);
        end

        // Reset in the middle of the clear sweep restarts it from address 0
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        run_clear(20);
        @(posedge clk); #1 reset = 0;
        run_clear(-1);
        check("clr2_busy", busy, 0);
        @(posedge clk); #1 a_req = 1; a_we = 0; a_addr = 63;
        @(negedge clk);
        check("rd63_gnt", a_gnt, 1);
        @(posedge clk); #1 a_req = 0;
        @(negedge clk);
        check("rd63_rv", a_rvalid, 1);
        check("rd63_data", a_rdata, 16'h0000);

        // Reset landing on a read grant drops the read
        @(posedge clk); #1 a_req = 1;
        @(negedge clk);
        check("drop_gnt", a_gnt, 1);
        reset = 1;
        #1;
        check("drop_gnt_rst", a_gnt, 0);
        @(posedge clk); #1;
        check("drop_rv1", a_rvalid, 0);
        a_req = 0; reset = 0;
        @(negedge clk);
        check("drop_rv2", a_rvalid, 0);
        check("drop_busy", busy, 1);
        check("drop_load", ram_load, 1);
        check("drop_addr", ram_addr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
